// File: rtl/pdm_mic_capture.sv
// rtl/pdm_mic_capture.sv - PDM microphone clock generator and stereo line capture
// Drives mic_clk and samples each shared line once per half period into per-mic bits.
module pdm_mic_capture #(
   parameter int N_LINES     = 4,
   parameter int CLK_DIV     = 8,
   parameter int WAKE_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [N_LINES-1:0]   pdm_data,
   output logic                 mic_clk,
   output logic [2*N_LINES-1:0] pdm_bits,
   output logic                 ena,
   output logic                 ready
);
   localparam int CW     = $clog2(CLK_DIV);
   localparam int WW_RAW = $clog2(WAKE_CYCLES + 1);
   localparam int WW     = (WW_RAW < 1) ? 1 : WW_RAW;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_RISE  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
   localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAKE  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [N_LINES-1:0]   sync1_q, sync2_q;
   logic [N_LINES-1:0]   l_hold_q, l_hold_d;
   logic [1:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WW-1:0]        wake_q, wake_d;
   logic                 mic_clk_q, mic_clk_d;
   logic                 ena_q, ena_d;
   logic                 ready_q, ready_d;
   logic [2*N_LINES-1:0] bits_q, bits_d;
   logic [2*N_LINES-1:0] bits_mix;
   logic                 wrap;
   logic [CW-1:0]        cnt_step;

   // Even bit of each pair is the L mic (held from the last high phase), odd bit is R (live).
   always_comb begin
      bits_mix = '0;
      for (int i = 0; i < N_LINES; i++) begin
         bits_mix[2*i]   = l_hold_q[i];
         bits_mix[2*i+1] = sync2_q[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wake_d   = wake_q;
      ready_d  = ready_q;
      ena_d    = 1'b0;
      bits_d   = bits_q;
      l_hold_d = l_hold_q;
      wrap     = (cnt_q == CNT_LAST);
      cnt_step = wrap ? '0 : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d = S_WAKE;
               wake_d  = '0;
            end
         end
         S_WAKE: begin
            cnt_d = cnt_step;
            if (!enable) begin
               state_d = wrap ? S_IDLE : S_DRAIN;
            end else if (wrap) begin
               wake_d = wake_q + 1'b1;
               if (wake_q == WAKE_LAST) begin
                  state_d = S_RUN;
                  ready_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_step;
            if (!enable) begin
               state_d = wrap ? S_IDLE : S_DRAIN;
               ready_d = 1'b0;
            end else if (cnt_q == CNT_RISE) begin
               ena_d  = 1'b1;
               bits_d = bits_mix;
            end
         end
         S_DRAIN: begin
            // Finish the current period so the high phase is never cut short.
            cnt_d = cnt_step;
            if (wrap) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ready_d = 1'b0;
         end
      endcase

      if (state_q != S_IDLE && wrap) l_hold_d = sync2_q;
      mic_clk_d = (cnt_d >= CNT_HALF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         l_hold_q  <= '0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wake_q    <= '0;
         mic_clk_q <= 1'b0;
         ena_q     <= 1'b0;
         ready_q   <= 1'b0;
         bits_q    <= '0;
      end else begin
         sync1_q   <= pdm_data;
         sync2_q   <= sync1_q;
         l_hold_q  <= l_hold_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wake_q    <= wake_d;
         mic_clk_q <= mic_clk_d;
         ena_q     <= ena_d;
         ready_q   <= ready_d;
         bits_q    <= bits_d;
      end
   end

   assign mic_clk  = mic_clk_q;
   assign pdm_bits = bits_q;
   assign ena      = ena_q;
   assign ready    = ready_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb/tb_pdm_mic_capture.sv - self-checking bench for pdm_mic_capture
// Stereo mic model drives the lines; expected strobes and bits come from period arithmetic.
module tb_pdm_mic_capture;
   localparam logic [3:0] FIX_L = 4'b1101;
   localparam logic [3:0] FIX_R = 4'b1110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable, enable2;
   logic [3:0] pdm_data;
   logic       mic_clk, ena, ready;
   logic [7:0] pdm_bits;
   logic       mic_clk2, ena2, ready2;
   logic [7:0] pdm_bits2;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   logic [3:0] cur_l, last_l, cur_r;
   logic       prev_mclk;
   bit         rand_mode;
   logic [7:0] exp_bits, exp_held;

   pdm_mic_capture #(.N_LINES(4), .CLK_DIV(8), .WAKE_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pdm_data(pdm_data),
      .mic_clk(mic_clk), .pdm_bits(pdm_bits), .ena(ena), .ready(ready)
   );

   pdm_mic_capture #(.N_LINES(4), .CLK_DIV(16), .WAKE_CYCLES(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .pdm_data(pdm_data),
      .mic_clk(mic_clk2), .pdm_bits(pdm_bits2), .ena(ena2), .ready(ready2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] weave(input logic [3:0] l, input logic [3:0] r);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b[2*i]   = l[i];
         b[2*i+1] = r[i];
      end
      return b;
   endfunction

   function automatic logic [3:0] new_bits(input logic [3:0] fix);
      if (rand_mode) return 4'($urandom);
      return fix;
   endfunction

   // One clk; the mic pair puts L on the line while mic_clk is high and R while low.
   task automatic tick();
      @(posedge clk);
      #1;
      exp_bits = weave(last_l, cur_r);
      if (mic_clk && !prev_mclk) cur_l = new_bits(FIX_L);
      if (!mic_clk && prev_mclk) begin
         last_l = cur_l;
         cur_r  = new_bits(FIX_R);
      end
      prev_mclk = mic_clk;
      pdm_data  = mic_clk ? cur_l : cur_r;
   endtask

   // Next posedge samples enable=1 in IDLE; k counts clks from that edge.
   task automatic run_window(input int ncyc, input string tag);
      int  n_ena   = 0;
      int  exp_ena = 0;
      bit  strobe;
      for (int k = 0; k < ncyc; k++) begin
         tick();
         strobe = (k >= 36) && (((k - 36) % 8) == 0);
         chk($sformatf("%s_mic_clk_k%0d", tag, k), 32'(mic_clk), 32'((k % 8) >= 4));
         chk($sformatf("%s_ready_k%0d", tag, k), 32'(ready), 32'(k >= 32));
         chk($sformatf("%s_ena_k%0d", tag, k), 32'(ena), 32'(strobe));
         if (strobe) begin
            exp_held = exp_bits;
            exp_ena++;
         end
         if (ena) n_ena++;
         chk($sformatf("%s_bits_k%0d", tag, k), 32'(pdm_bits), 32'(exp_held));
      end
      chk($sformatf("%s_ena_count", tag), 32'(n_ena), 32'(exp_ena));
   endtask

   initial begin
      int n_ena2;
      int exp_ena2;
      bit strobe2;

      rst_n     = 1'b0;
      enable    = 1'b0;
      enable2   = 1'b0;
      rand_mode = 1'b0;
      cur_l     = FIX_L;
      last_l    = FIX_L;
      cur_r     = FIX_R;
      prev_mclk = 1'b0;
      exp_held  = '0;
      exp_bits  = '0;
      pdm_data  = FIX_R;

      // Reset held while inputs toggle
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         enable   = i[0];
         enable2  = ~i[0];
         pdm_data = 4'($urandom);
      end
      chk("rst_mic_clk", 32'(mic_clk), 32'd0);
      chk("rst_ena", 32'(ena), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_bits", 32'(pdm_bits), 32'd0);
      chk("rst_mic_clk2", 32'(mic_clk2), 32'd0);
      chk("rst_ready2", 32'(ready2), 32'd0);

      enable   = 1'b0;
      enable2  = 1'b0;
      pdm_data = cur_r;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();
      chk("idle_mic_clk", 32'(mic_clk), 32'd0);
      chk("idle_ready", 32'(ready), 32'd0);

      // Wake timing and fixed stereo pattern
      enable = 1'b1;
      run_window(126, "fixed");
      chk("fixed_pattern", 32'(pdm_bits), 32'h0000_00F9);

      // Drop enable while cnt==5: high phase completes, then frozen
      enable = 1'b0;
      tick();
      chk("drop_ready", 32'(ready), 32'd0);
      chk("drop_mic_cnt6", 32'(mic_clk), 32'd1);
      tick();
      chk("drop_mic_cnt7", 32'(mic_clk), 32'd1);
      chk("drop_ena_cnt7", 32'(ena), 32'd0);
      for (int j = 0; j < 20; j++) begin
         tick();
         chk($sformatf("frozen_mic_%0d", j), 32'(mic_clk), 32'd0);
         chk($sformatf("frozen_ena_%0d", j), 32'(ena), 32'd0);
         chk($sformatf("frozen_ready_%0d", j), 32'(ready), 32'd0);
      end

      // Random bitstreams: 2000 RUN periods
      rand_mode = 1'b1;
      enable    = 1'b1;
      run_window(16034, "rand");

      // Re-enable during DRAIN: ignored until IDLE, then a full wake
      enable = 1'b0;
      tick();
      chk("drain_ready", 32'(ready), 32'd0);
      enable = 1'b1;
      for (int j = 3; j < 8; j++) begin
         tick();
         chk($sformatf("drain_mic_cnt%0d", j), 32'(mic_clk), 32'(j >= 4));
         chk($sformatf("drain_ena_cnt%0d", j), 32'(ena), 32'd0);
         chk($sformatf("drain_ready_cnt%0d", j), 32'(ready), 32'd0);
      end
      tick();
      chk("drain_idle_mic", 32'(mic_clk), 32'd0);
      run_window(40, "rewake");

      // Asynchronous reset mid-RUN, between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_mic_clk", 32'(mic_clk), 32'd0);
      chk("async_ready", 32'(ready), 32'd0);
      chk("async_ena", 32'(ena), 32'd0);
      chk("async_bits", 32'(pdm_bits), 32'd0);

      // CLK_DIV=16, WAKE_CYCLES=0
      enable = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      enable2  = 1'b1;
      n_ena2   = 0;
      exp_ena2 = 0;
      for (int k = 0; k < 160; k++) begin
         tick();
         strobe2 = (k >= 24) && (((k - 24) % 16) == 0);
         chk($sformatf("d16_mic_clk_k%0d", k), 32'(mic_clk2), 32'((k % 16) >= 8));
         chk($sformatf("d16_ready_k%0d", k), 32'(ready2), 32'(k >= 16));
         chk($sformatf("d16_ena_k%0d", k), 32'(ena2), 32'(strobe2));
         if (strobe2) exp_ena2++;
         if (ena2) n_ena2++;
      end
      chk("d16_ena_count", 32'(n_ena2), 32'(exp_ena2));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
